// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bundle: RAM instruction port, redirect/halt control and the
// valid/ready instruction stream towards decode.
interface inst_fetch_unit_if;
    logic [15:0] instAddr;
    logic [31:0] instOut;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [31:0] inst;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    // Fetch unit side.
    modport master (
        output instAddr,
        output inst,
        output inst_pc,
        output inst_valid,
        input  instOut,
        input  redirect,
        input  redirect_pc,
        input  halt,
        input  inst_ready
    );

    // RAM / control / decode side.
    modport slave (
        input  instAddr,
        input  inst,
        input  inst_pc,
        input  inst_valid,
        output instOut,
        output redirect,
        output redirect_pc,
        output halt,
        output inst_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one fetch per cycle to the RAM
// instruction port, tags each returning word with its PC and buffers it in a
// small FIFO presented to decode over valid/ready. Supports redirect and halt.
module inst_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd4,
    parameter int unsigned DEPTH    = 2
) (
    input logic              clk,
    input logic              rst,
    inst_fetch_unit_if.master bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef logic [AW-1:0] ptr_t;

    logic [15:0] pc_q, pc_d;
    logic [15:0] tag_q, tag_d;
    logic        inflight_q, inflight_d;
    logic [CW-1:0] count_q, count_d;
    ptr_t        rd_q, rd_d;
    ptr_t        wr_q, wr_d;

    logic [31:0] data_mem [DEPTH];
    logic [15:0] pc_mem [DEPTH];

    logic        pop;
    logic        push;
    logic        issue;
    logic [CW:0] occupancy;

    // Handshake decode and issue gating; an issue reserves a FIFO slot so the
    // response one cycle later can never overflow.
    always_comb begin
        pop       = bus.inst_valid && bus.inst_ready;
        push      = inflight_q && !bus.redirect;
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
        issue     = !rst && !bus.redirect && !bus.halt && (occupancy < DEPTH_W);
    end

    // Next-state for PC, in-flight tag and FIFO bookkeeping; redirect flushes.
    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = issue;
        count_d    = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        rd_d       = pop ? rd_q + ptr_t'(1) : rd_q;
        wr_d       = push ? wr_q + ptr_t'(1) : wr_q;
        if (issue) begin
            pc_d  = pc_q + PC_STEP;
            tag_d = pc_q;
        end
        if (bus.redirect) begin
            pc_d       = bus.redirect_pc;
            inflight_d = 1'b0;
            count_d    = '0;
            rd_d       = '0;
            wr_d       = '0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            tag_q      <= RESET_PC;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    // FIFO storage: returning RAM word captured together with its PC tag.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            data_mem[wr_q] <= bus.instOut;
            pc_mem[wr_q]   <= tag_q;
        end
    end

    assign bus.instAddr   = pc_q;
    assign bus.inst       = data_mem[rd_q];
    assign bus.inst_pc    = pc_mem[rd_q];
    assign bus.inst_valid = (count_q != '0);

endmodule
